gouram_trace_drain: RTL and testbench

Downstream consumer of the gouram trace unit: captures each 128-bit trace record presented with `trace_capture_enable`, buffers records in a synchronous FIFO, and streams them out as four 32-bit beats over a valid/ready interface to the trace sink (DMA or debug port). It absorbs bursts from the tracer, counts records lost to overflow, and never back-pressures the tracer.

---
 rtl/gouram_drain_pkg.sv | 28 ++
 rtl/gouram_trace_fifo.sv | 53 +++++
 rtl/gouram_trace_drain.sv | 122 ++++++++++++
 tb/tb_gouram_trace_drain.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gouram_drain_pkg.sv
// Shared widths, serializer state type and beat selection for the gouram trace drain.
package gouram_drain_pkg;

    localparam int TRACE_WIDTH      = 128;
    localparam int BEAT_WIDTH       = 32;
    localparam int BEATS_PER_RECORD = 4;

    typedef enum logic {
        IDLE,
        SEND
    } drain_state_t;

    // Beat 0 is the least significant word of the record.
    function automatic logic [BEAT_WIDTH-1:0] select_beat(
        input logic [TRACE_WIDTH-1:0] rec,
        input logic [1:0]             idx
    );
        logic [BEAT_WIDTH-1:0] beat;
        case (idx)
            2'd0:    beat = rec[31:0];
            2'd1:    beat = rec[63:32];
            2'd2:    beat = rec[95:64];
            default: beat = rec[127:96];
        endcase
        return beat;
    endfunction

endpackage

// File: rtl/gouram_trace_fifo.sv
// Synchronous record FIFO with one extra pointer bit to tell full from empty.
module gouram_trace_fifo
    import gouram_drain_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = TRACE_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign level   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_ptr[AW-1:0]];
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_push = push && (!full || pop) && !clear;
    assign do_pop  = pop && !empty && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/gouram_trace_drain.sv
// Buffers 128-bit gouram trace records and streams each one as four 32-bit beats,
// dropping (and counting) records that arrive while the FIFO is full.
module gouram_trace_drain
    import gouram_drain_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [TRACE_WIDTH-1:0]        trace_data_i,
    input  logic                          trace_capture_enable,
    input  logic                          clear,
    output logic [BEAT_WIDTH-1:0]         m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [DROP_CNT_WIDTH-1:0]     drop_count,
    output logic                          overflow
);

    drain_state_t           state;
    logic [1:0]             beat_idx;
    logic [1:0]             next_idx;
    logic [TRACE_WIDTH-1:0] holding;
    logic [TRACE_WIDTH-1:0] fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   last_accept;
    logic                   pop;
    logic                   push;
    logic                   drop;

    assign next_idx    = beat_idx + 2'd1;
    assign last_accept = (state == SEND) && m_ready && (beat_idx == 2'd3);
    assign pop         = !clear && !fifo_empty && ((state == IDLE) || last_accept);
    assign push        = trace_capture_enable && !clear && (!fifo_full || pop);
    assign drop        = trace_capture_enable && !clear && fifo_full && !pop;

    gouram_trace_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (TRACE_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (push),
        .wdata (trace_data_i),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Serializer: the outputs are registered so a stalled beat stays frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_idx <= 2'd0;
            holding  <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_last   <= 1'b0;
        end else if (clear) begin
            state    <= IDLE;
            beat_idx <= 2'd0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_last   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        holding  <= fifo_rdata;
                        beat_idx <= 2'd0;
                        m_valid  <= 1'b1;
                        m_data   <= select_beat(fifo_rdata, 2'd0);
                        m_last   <= 1'b0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (m_ready) begin
                        if (beat_idx != 2'd3) begin
                            beat_idx <= next_idx;
                            m_data   <= select_beat(holding, next_idx);
                            m_last   <= (next_idx == 2'd3);
                        end else if (pop) begin
                            holding  <= fifo_rdata;
                            beat_idx <= 2'd0;
                            m_data   <= select_beat(fifo_rdata, 2'd0);
                            m_last   <= 1'b0;
                        end else begin
                            beat_idx <= 2'd0;
                            m_valid  <= 1'b0;
                            m_data   <= '0;
                            m_last   <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (clear) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_gouram_trace_drain.sv
// Table vectors, directed corner sequences and random traffic checked against a
// queue-based model of the trace drain.
module tb_gouram_trace_drain;

    localparam int DEPTH = 8;

    typedef struct {
        bit           cap;
        logic [127:0] data;
        bit           exp_valid;
        logic [31:0]  exp_data;
        bit           exp_last;
        int           exp_level;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] trace_data_i;
    logic         trace_capture_enable;
    logic         clear;
    logic [31:0]  m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;
    logic [3:0]   fifo_level;
    logic [15:0]  drop_count;
    logic         overflow;

    int vectors = 0;
    int miscompares = 0;

    logic [127:0] model_q[$];
    logic [127:0] model_cur;
    int           model_left;
    int           model_drop;
    bit           model_ovf;

    vec_t         table_v[$];
    logic [127:0] recs[$];
    logic [31:0]  exp_beats[$];

    always #5 clk = ~clk;

    gouram_trace_drain #(
        .FIFO_DEPTH     (DEPTH),
        .DROP_CNT_WIDTH (16)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .trace_data_i         (trace_data_i),
        .trace_capture_enable (trace_capture_enable),
        .clear                (clear),
        .m_data               (m_data),
        .m_valid              (m_valid),
        .m_ready              (m_ready),
        .m_last               (m_last),
        .fifo_level           (fifo_level),
        .drop_count           (drop_count),
        .overflow             (overflow)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        model_cur  = '0;
        model_left = 0;
        model_drop = 0;
        model_ovf  = 1'b0;
    endtask

    // One clock edge of the drain, expressed as records and beats remaining.
    task automatic modelEdge(input bit cap, input logic [127:0] d, input bit rdy, input bit clr);
        bit pop_now;
        if (clr) begin
            modelReset();
            return;
        end
        pop_now = (model_q.size() > 0) && ((model_left == 0) || (model_left == 1 && rdy));
        if (model_left > 0 && rdy) model_left--;
        if (pop_now) begin
            model_cur  = model_q.pop_front();
            model_left = 4;
        end
        if (cap) begin
            if (model_q.size() < DEPTH) begin
                model_q.push_back(d);
            end else begin
                model_ovf = 1'b1;
                if (model_drop < 65535) model_drop++;
            end
        end
    endtask

    task automatic checkModel();
        logic [31:0] exp_d;
        exp_d = (model_left > 0) ? model_cur[32*(4-model_left) +: 32] : 32'h0;
        checkOutput("m_valid", 64'(m_valid), 64'(model_left > 0));
        checkOutput("m_data", 64'(m_data), 64'(exp_d));
        checkOutput("m_last", 64'(m_last), 64'(model_left == 1));
        checkOutput("fifo_level", 64'(fifo_level), 64'(model_q.size()));
        checkOutput("drop_count", 64'(drop_count), 64'(model_drop));
        checkOutput("overflow", 64'(overflow), 64'(model_ovf));
    endtask

    task automatic applyStimulus(input bit cap, input logic [127:0] d, input bit rdy, input bit clr);
        trace_capture_enable = cap;
        trace_data_i         = d;
        m_ready              = rdy;
        clear                = clr;
        @(posedge clk);
        modelEdge(cap, d, rdy, clr);
        #1;
        checkModel();
    endtask

    task automatic addRow(input bit cap, input logic [127:0] d, input bit v,
                          input logic [31:0] ed, input bit l, input int lvl);
        vec_t r;
        r.cap = cap; r.data = d; r.exp_valid = v; r.exp_data = ed; r.exp_last = l; r.exp_level = lvl;
        table_v.push_back(r);
    endtask

    function automatic logic [127:0] randRec();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [127:0] r1, r2, r3, rx;
        int got;
        int guard;

        r1 = 128'h0000000D_0000000C_0000000B_0000000A;
        r2 = 128'h44444444_33333333_22222222_11111111;
        r3 = 128'h88888888_77777777_66666666_55555555;
        addRow(1, r1, 0, 32'h0, 0, 1);
        addRow(0, '0, 1, 32'hA, 0, 0);
        addRow(0, '0, 1, 32'hB, 0, 0);
        addRow(0, '0, 1, 32'hC, 0, 0);
        addRow(0, '0, 1, 32'hD, 1, 0);
        addRow(0, '0, 0, 32'h0, 0, 0);
        addRow(1, r2, 0, 32'h0, 0, 1);
        addRow(1, r3, 1, 32'h11111111, 0, 1);
        addRow(0, '0, 1, 32'h22222222, 0, 1);
        addRow(0, '0, 1, 32'h33333333, 0, 1);
        addRow(0, '0, 1, 32'h44444444, 1, 1);
        addRow(0, '0, 1, 32'h55555555, 0, 0);
        addRow(0, '0, 1, 32'h66666666, 0, 0);
        addRow(0, '0, 1, 32'h77777777, 0, 0);
        addRow(0, '0, 1, 32'h88888888, 1, 0);
        addRow(0, '0, 0, 32'h0, 0, 0);

        rst_n = 1'b0;
        trace_capture_enable = 1'b0;
        trace_data_i = '0;
        clear = 1'b0;
        m_ready = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", 64'(m_valid), 64'h0);
        checkOutput("reset_data", 64'(m_data), 64'h0);
        checkOutput("reset_level", 64'(fifo_level), 64'h0);
        checkOutput("reset_drop", 64'(drop_count), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < table_v.size(); i++) begin
            applyStimulus(table_v[i].cap, table_v[i].data, 1'b1, 1'b0);
            checkOutput($sformatf("tbl%0d_valid", i), 64'(m_valid), 64'(table_v[i].exp_valid));
            checkOutput($sformatf("tbl%0d_data", i), 64'(m_data), 64'(table_v[i].exp_data));
            checkOutput($sformatf("tbl%0d_last", i), 64'(m_last), 64'(table_v[i].exp_last));
            checkOutput($sformatf("tbl%0d_level", i), 64'(fifo_level), 64'(table_v[i].exp_level));
        end

        // Overflow: sink stalled, ten captures, the tenth is lost.
        for (int i = 0; i < 10; i++) recs.push_back(randRec());
        for (int i = 0; i < 20; i++) applyStimulus(i < 10, (i < 10) ? recs[i] : '0, 1'b0, 1'b0);
        checkOutput("ovf_level", 64'(fifo_level), 64'd8);
        checkOutput("ovf_drop", 64'(drop_count), 64'd1);
        checkOutput("ovf_sticky", 64'(overflow), 64'd1);
        checkOutput("ovf_head", 64'(m_data), 64'(recs[0][31:0]));
        for (int i = 0; i < 9; i++)
            for (int b = 0; b < 4; b++) exp_beats.push_back(recs[i][32*b +: 32]);
        got = 0;
        for (int c = 0; c < 200 && got < 36; c++) begin
            if (m_valid) begin
                checkOutput($sformatf("ovf_beat%0d", got), 64'(m_data), 64'(exp_beats[got]));
                got++;
            end
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
        checkOutput("ovf_beat_count", 64'(got), 64'd36);
        checkOutput("ovf_drop_kept", 64'(drop_count), 64'd1);

        // Clear in the middle of a record with three more queued.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, randRec(), 1'b0, 1'b0);
        checkOutput("clr_pre_level", 64'(fifo_level), 64'd3);
        guard = 0;
        while (model_left != 2 && guard < 10) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            guard++;
        end
        checkOutput("clr_reached_beat2", 64'(model_left), 64'd2);
        applyStimulus(1'b1, randRec(), 1'b1, 1'b1);
        checkOutput("clr_valid", 64'(m_valid), 64'h0);
        checkOutput("clr_level", 64'(fifo_level), 64'h0);
        checkOutput("clr_drop", 64'(drop_count), 64'h0);
        checkOutput("clr_ovf", 64'(overflow), 64'h0);
        rx = randRec();
        applyStimulus(1'b1, rx, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("clr_next_beat0", 64'(m_data), 64'(rx[31:0]));
        repeat (5) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Random traffic with stalls and occasional clears.
        for (int i = 0; i < 1500; i++)
            applyStimulus(($urandom_range(0, 9) < 3), randRec(), ($urandom_range(0, 9) < 6),
                          ($urandom_range(0, 299) == 0));

        // Asynchronous reset in the middle of a stream.
        applyStimulus(1'b1, randRec(), 1'b1, 1'b0);
        applyStimulus(1'b1, randRec(), 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("arst_pre_valid", 64'(m_valid), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", 64'(m_valid), 64'h0);
        checkOutput("arst_data", 64'(m_data), 64'h0);
        checkOutput("arst_last", 64'(m_last), 64'h0);
        checkOutput("arst_level", 64'(fifo_level), 64'h0);
        checkOutput("arst_drop", 64'(drop_count), 64'h0);
        checkOutput("arst_ovf", 64'(overflow), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        rx = randRec();
        applyStimulus(1'b1, rx, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("arst_next_beat0", 64'(m_data), 64'(rx[31:0]));
        repeat (5) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
